// File: rtl/vga_pkg.sv
// Shared display geometry and scheduler types for the sprite motion block.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 1024;
  localparam int unsigned VER_PIXELS = 768;

  typedef enum logic [1:0] {
    IDLE,
    UPD0,
    UPD1,
    COMMIT
  } upd_state_t;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        dx;
    logic        dy;
  } sprite_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing stream bundle; producers drive the out side, consumers read the in side.
interface vga_if;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk);

endinterface

// File: rtl/bounce_axis.sv
// One-axis bounce step: advances a position by STEP and reflects at 0 or MAX-SIZE.
module bounce_axis #(
  parameter int unsigned MAX  = 1024,
  parameter int unsigned SIZE = 64,
  parameter int unsigned STEP = 2
) (
  input  logic [11:0] pos,
  input  logic        dir,
  output logic [11:0] next_pos,
  output logic        next_dir
);

  localparam logic [12:0] LIMIT  = 13'(MAX - SIZE);
  localparam logic [12:0] STEP13 = 13'(STEP);

  logic [12:0] pos13;
  logic [12:0] fwd;

  assign pos13 = {1'b0, pos};
  assign fwd   = pos13 + STEP13;

  // dir=1 means moving towards larger coordinates
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    if (dir) begin
      if (fwd > LIMIT) begin
        next_pos = LIMIT[11:0];
        next_dir = 1'b0;
      end else begin
        next_pos = fwd[11:0];
      end
    end else begin
      if (pos13 < STEP13) begin
        next_pos = '0;
        next_dir = 1'b1;
      end else begin
        next_pos = 12'(pos13 - STEP13);
      end
    end
  end

endmodule

// File: rtl/sprite_motion_scheduler.sv
// Per-frame position scheduler for two bouncing sprites; new positions are
// computed into shadows during vertical blanking and committed in one cycle.
module sprite_motion_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned RECT_WIDTH  = 64,
  parameter int unsigned RECT_HEIGHT = 64,
  parameter int unsigned STEP        = 2,
  parameter int unsigned S0_X0       = 150,
  parameter int unsigned S0_Y0       = 150,
  parameter int unsigned S1_X0       = 850,
  parameter int unsigned S1_Y0       = 450
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           in,
  input  logic        run,
  output logic [11:0] s0_x_pos,
  output logic [11:0] s0_y_pos,
  output logic [11:0] s1_x_pos,
  output logic [11:0] s1_y_pos,
  output logic [15:0] frame_cnt
);

  localparam sprite_t S0_RST = '{x: 12'(S0_X0), y: 12'(S0_Y0), dx: 1'b1, dy: 1'b1};
  localparam sprite_t S1_RST = '{x: 12'(S1_X0), y: 12'(S1_Y0), dx: 1'b1, dy: 1'b1};

  upd_state_t state, state_nxt;
  logic       vblnk_q;
  logic       vblnk_rise;
  logic       ld_sh0, ld_sh1, commit;

  sprite_t cur0, cur1;
  sprite_t sh0, sh1;
  sprite_t src;
  sprite_t stepped;

  assign vblnk_rise = in.vblnk & ~vblnk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q <= 1'b0;
      state   <= IDLE;
    end else begin
      vblnk_q <= in.vblnk;
      state   <= state_nxt;
    end
  end

  // run is only consulted at the edge; an accepted update always completes
  always_comb begin
    state_nxt = state;
    ld_sh0    = 1'b0;
    ld_sh1    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE:    if (vblnk_rise && run) state_nxt = UPD0;
      UPD0:    begin ld_sh0 = 1'b1; state_nxt = UPD1;   end
      UPD1:    begin ld_sh1 = 1'b1; state_nxt = COMMIT; end
      COMMIT:  begin commit = 1'b1; state_nxt = IDLE;   end
      default: state_nxt = IDLE;
    endcase
  end

  // A single pair of axis steppers serves both sprites, selected by state
  assign src = (state == UPD1) ? cur1 : cur0;

  bounce_axis #(
    .MAX  (HOR_PIXELS),
    .SIZE (RECT_WIDTH),
    .STEP (STEP)
  ) u_bounce_x (
    .pos      (src.x),
    .dir      (src.dx),
    .next_pos (stepped.x),
    .next_dir (stepped.dx)
  );

  bounce_axis #(
    .MAX  (VER_PIXELS),
    .SIZE (RECT_HEIGHT),
    .STEP (STEP)
  ) u_bounce_y (
    .pos      (src.y),
    .dir      (src.dy),
    .next_pos (stepped.y),
    .next_dir (stepped.dy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh0       <= S0_RST;
      sh1       <= S1_RST;
      cur0      <= S0_RST;
      cur1      <= S1_RST;
      frame_cnt <= '0;
    end else begin
      if (ld_sh0) sh0 <= stepped;
      if (ld_sh1) sh1 <= stepped;
      if (commit) begin
        cur0      <= sh0;
        cur1      <= sh1;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign s0_x_pos = cur0.x;
  assign s0_y_pos = cur0.y;
  assign s1_x_pos = cur1.x;
  assign s1_y_pos = cur1.y;

endmodule

// File: tb/tb_sprite_motion_scheduler.sv
// Randomized scoreboard bench: a reflecting-motion model predicts every commit.
module tb_sprite_motion_scheduler;

  localparam int HOR  = 1024;
  localparam int VER  = 768;
  localparam int STP  = 2;
  localparam int WA   = 64;
  localparam int WB   = 63;
  localparam int HGT  = 64;

  typedef struct {
    int s0x, s0y, s1x, s1y, fc;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic run;
  vga_if vif ();

  logic [11:0] a_s0x, a_s0y, a_s1x, a_s1y;
  logic [11:0] b_s0x, b_s0y, b_s1x, b_s1y;
  logic [15:0] a_fc, b_fc;

  always #5 clk = ~clk;

  sprite_motion_scheduler dut_a (
    .clk       (clk),
    .rst       (rst),
    .in        (vif),
    .run       (run),
    .s0_x_pos  (a_s0x),
    .s0_y_pos  (a_s0y),
    .s1_x_pos  (a_s1x),
    .s1_y_pos  (a_s1y),
    .frame_cnt (a_fc)
  );

  sprite_motion_scheduler #(
    .RECT_WIDTH (WB),
    .S0_X0      (957)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in        (vif),
    .run       (run),
    .s0_x_pos  (b_s0x),
    .s0_y_pos  (b_s0y),
    .s1_x_pos  (b_s1x),
    .s1_y_pos  (b_s1y),
    .frame_cnt (b_fc)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  exp_t qa[$];
  exp_t qb[$];

  int mp [2][4];
  bit md [2][4];
  int mfc;
  bit saw_low_bounce;
  bit saw_right_hold;
  int prev [2][5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0d required=%0d at cycle %0d", name, inst, act, req, cyc);
    end
  endtask

  function automatic int limit_of(input int inst, input int k);
    if (k % 2 == 0) return HOR - ((inst == 0) ? WA : WB);
    return VER - HGT;
  endfunction

  // Reflect off [0, lim]: overshoot clamps to the wall and reverses
  function automatic void axis_step(inout int p, inout bit d, input int lim);
    if (d) begin
      if (p + STP > lim) begin p = lim; d = 1'b0; end
      else p = p + STP;
    end else begin
      if (p < STP) begin p = 0; d = 1'b1; end
      else p = p - STP;
    end
  endfunction

  task automatic model_reset();
    mp[0][0] = 150; mp[0][1] = 150; mp[0][2] = 850; mp[0][3] = 450;
    mp[1][0] = 957; mp[1][1] = 150; mp[1][2] = 850; mp[1][3] = 450;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) md[i][k] = 1'b1;
    mfc = 0;
  endtask

  task automatic model_frame(input int unsigned edge_cyc);
    exp_t e;
    if (mp[1][0] == 1 && !md[1][0]) saw_low_bounce = 1'b1;
    if (mp[0][2] == 960 && md[0][2]) saw_right_hold = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) axis_step(mp[i][k], md[i][k], limit_of(i, k));
    mfc = (mfc + 1) % 65536;
    for (int i = 0; i < 2; i++) begin
      e.s0x = mp[i][0]; e.s0y = mp[i][1]; e.s1x = mp[i][2]; e.s1y = mp[i][3];
      e.fc = mfc;
      e.cyc = edge_cyc + 3;
      if (i == 0) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  task automatic mon(input int inst, input bit active, input int x0, input int y0,
                     input int x1, input int y1, input int fc);
    int cur [5];
    bit pos_chg;
    int qlen;
    exp_t e;
    cur[0] = x0; cur[1] = y0; cur[2] = x1; cur[3] = y1; cur[4] = fc;
    if (active) begin
      pos_chg = 1'b0;
      for (int k = 0; k < 4; k++) if (cur[k] != prev[inst][k]) pos_chg = 1'b1;
      qlen = (inst == 0) ? qa.size() : qb.size();
      if (cur[4] != prev[inst][4]) begin
        if (qlen == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update[%0d] actual frame_cnt=%0d required no update", inst, fc);
        end else begin
          e = (inst == 0) ? qa.pop_front() : qb.pop_front();
          chk("s0_x", inst, x0, e.s0x);
          chk("s0_y", inst, y0, e.s0y);
          chk("s1_x", inst, x1, e.s1x);
          chk("s1_y", inst, y1, e.s1y);
          chk("frame_cnt", inst, fc, e.fc);
          chk("commit_cycle", inst, int'(cyc), int'(e.cyc));
          chk("vblnk_at_commit", inst, int'(vif.vblnk), 1);
        end
      end else if (pos_chg) begin
        checks++; errors++;
        $display("FAIL pos_change_without_commit[%0d] actual s0=(%0d,%0d) s1=(%0d,%0d) required unchanged",
                 inst, x0, y0, x1, y1);
      end
    end
    for (int k = 0; k < 5; k++) prev[inst][k] = cur[k];
  endtask

  always @(negedge clk) begin
    mon(0, rst, a_s0x, a_s0y, a_s1x, a_s1y, a_fc);
    mon(1, rst, b_s0x, b_s0y, b_s1x, b_s1y, b_fc);
  end

  task automatic check_reset_vals();
    chk("rst_s0_x", 0, a_s0x, 150); chk("rst_s0_y", 0, a_s0y, 150);
    chk("rst_s1_x", 0, a_s1x, 850); chk("rst_s1_y", 0, a_s1y, 450);
    chk("rst_frame_cnt", 0, a_fc, 0);
    chk("rst_s0_x", 1, b_s0x, 957); chk("rst_frame_cnt", 1, b_fc, 0);
  endtask

  task automatic check_first_frame();
    chk("first_s0_x", 0, a_s0x, 152); chk("first_s0_y", 0, a_s0y, 152);
    chk("first_s1_x", 0, a_s1x, 852); chk("first_s1_y", 0, a_s1y, 452);
    chk("first_frame_cnt", 0, a_fc, 1);
  endtask

  // vblnk high for hi cycles, low for lo cycles; run varies freely after the edge
  task automatic do_frame(input bit r, input int hi, input int lo);
    @(negedge clk);
    vif.vblnk = 1'b1;
    run = r;
    if (r) model_frame(cyc + 1);
    repeat (hi - 1) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    vif.vblnk = 1'b0;
    repeat (lo - 1) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    vif.vblnk = 1'b0; vif.vsync = 1'b0; vif.hsync = 1'b0; vif.hblnk = 1'b0;
    vif.vcount = '0; vif.hcount = '0;
    saw_low_bounce = 1'b0;
    saw_right_hold = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_frame(1'b1, 6, 5);
    check_first_frame();

    for (int i = 0; i < 3; i++) do_frame(1'b0, 6, 5);
    check_first_frame();

    // Reset arrives while the FSM is in UPD1
    @(negedge clk);
    vif.vblnk = 1'b1;
    run = 1'b1;
    model_frame(cyc + 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals();
    qa.delete();
    qb.delete();
    model_reset();
    @(negedge clk);
    vif.vblnk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    do_frame(1'b1, 7, 4);
    check_first_frame();

    for (int i = 0; i < 800; i++)
      do_frame($urandom_range(0, 7) != 0, $urandom_range(5, 12), $urandom_range(4, 10));

    repeat (10) @(negedge clk);
    chk("pending_updates", 0, qa.size(), 0);
    chk("pending_updates", 1, qb.size(), 0);
    chk("final_frame_cnt", 0, a_fc, mfc);
    chk("low_wall_reached", 1, int'(saw_low_bounce), 1);
    chk("right_wall_reached", 0, int'(saw_right_hold), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_motion_scheduler.md
SPRITE_MOTION_SCHEDULER -- requirements
Module: sprite_motion_scheduler

Interface
REQ-001 Parameter RECT_WIDTH, default 64, sprite width in pixels.
REQ-002 Parameter RECT_HEIGHT, default 64, sprite height in pixels.
REQ-003 Parameter STEP, default 2, pixels moved per axis per frame.
REQ-004 Parameter S0_X0/S0_Y0, default 150/150, sprite-0 reset position.
REQ-005 Parameter S1_X0/S1_Y0, default 850/450, sprite-1 reset position.
REQ-006 clk  input  1  pixel clock; the single clock of the block.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 in  vga_if.in  --  timing stream; only vblnk is used.
REQ-009 run  input  1  1 = advance motion each frame; 0 = freeze positions.
REQ-010 s0_x_pos, s0_y_pos  output  12 each  sprite-0 top-left position for a draw_image instance.
REQ-011 s1_x_pos, s1_y_pos  output  12 each  sprite-1 top-left position for a draw_image instance.
REQ-012 frame_cnt  output  16  count of committed updates, wraps modulo 2^16.

Function
REQ-013 A vblnk rising edge SHALL be detected with a 1-cycle registered copy of in.vblnk: vblnk=1 while the copy is 0.
REQ-014 FSM states SHALL be IDLE, UPD0, UPD1, COMMIT.
REQ-015 IDLE->UPD0 on a detected edge with run=1; stay in IDLE otherwise (edge with run=0 is ignored).
REQ-016 UPD0 SHALL compute next sprite-0 position and direction into shadow registers, then go to UPD1.
REQ-017 UPD1 SHALL do the same for sprite 1, then go to COMMIT.
REQ-018 COMMIT SHALL copy the shadow registers to the outputs, increment frame_cnt, and return to IDLE; outputs change on the 4th clk after the edge cycle.
REQ-019 Outputs SHALL change only in COMMIT, so positions are constant across every active frame.
REQ-020 Per axis, moving positive: if pos+STEP > MAX-size, next = MAX-size and direction flips; else next = pos+STEP.
REQ-021 Per axis, moving negative: if pos < STEP, next = 0 and direction flips; else next = pos-STEP.
REQ-022 MAX SHALL be HOR_PIXELS for x and VER_PIXELS for y; all arithmetic is 13-bit unsigned to avoid overflow.
REQ-023 A position exactly at a limit SHALL produce next = limit with direction flipped, e.g. x=960 moving + gives 960 then 958.
REQ-024 run deasserting in UPD0, UPD1 or COMMIT SHALL NOT abort the update in progress.
REQ-025 Edges arriving outside IDLE SHALL be ignored; none can occur within 3 cycles with legal timing.

Reset
REQ-026 While rst=0: FSM in IDLE, vblnk copy 0, frame_cnt 0.
REQ-027 While rst=0: outputs and shadows hold S0_X0/S0_Y0 and S1_X0/S1_Y0; all directions positive.
REQ-028 Reset asserted mid-update SHALL discard the partial update; the first edge after release starts a fresh update.

Structure
REQ-029 HOR_PIXELS and VER_PIXELS SHALL come from vga_pkg, together with the FSM state enum type.
REQ-030 The per-axis bounce step SHALL be one sub-module, bounce_axis, instanced for x and y and shared by UPD0/UPD1 through a multiplexer.
REQ-031 Outputs SHALL connect directly to the rect_x_pos/rect_y_pos inputs of draw_image instances.

Verification
REQ-032 Reset release, run=1, one vblnk edge -> s0=(152,152), s1=(852,452), frame_cnt=1, 4 clocks after the edge.
REQ-033 run=0 for 3 frames -> positions and frame_cnt unchanged.
REQ-034 Sprite 1 from reset, 55 frames -> s1_x reaches 960 and then reads 958; y direction unaffected.
REQ-035 s0_x forced near 0 moving negative with pos=1 -> next 0, direction flips, following frame 2.
REQ-036 rst pulsed low during UPD1 -> outputs return to reset positions, frame_cnt=0; next edge gives the REQ-032 values.
REQ-037 vblnk held high for many cycles -> exactly one update per high period; outputs never change while vblnk=0.
